// File: rtl/fault_coverage_collector.sv
// Sink for parallel stuck-at fault-simulator detect words: coverage masks, first-detect table, counts.
// Optional macro FAULT_COLLECT_EARLY_STOP_EN closes the session as soon as every fault is covered.
module fault_coverage_collector #(
   parameter int NUM_NETS = 8,
   parameter int VEC_W    = 4
) (
   input  logic                                CLK,
   input  logic                                RST,
   input  logic                                START,
   input  logic                                IN_VALID,
   output logic                                IN_READY,
   input  logic [VEC_W-1:0]                    IN_VECTOR,
   input  logic [NUM_NETS-1:0]                 IN_DETECT_SA0,
   input  logic [NUM_NETS-1:0]                 IN_DETECT_SA1,
   input  logic                                IN_LAST,
   output logic [NUM_NETS-1:0]                 COVERED_SA0,
   output logic [NUM_NETS-1:0]                 COVERED_SA1,
   output logic [$clog2(2*NUM_NETS+1)-1:0]     DET_COUNT,
   output logic [VEC_W:0]                      VEC_COUNT,
   output logic                                DONE,
   output logic                                FULL_COVERAGE,
   input  logic                                RD_EN,
   input  logic [$clog2(2*NUM_NETS):0]         RD_ADDR,
   output logic                                RD_VALID,
   output logic                                RD_DETECTED,
   output logic [VEC_W-1:0]                    RD_FIRST_VEC
);
   localparam int NF     = 2 * NUM_NETS;
   localparam int DET_W  = $clog2(2 * NUM_NETS + 1);
   localparam int ADDR_W = $clog2(2 * NUM_NETS) + 1;
   localparam int VCNT_W = VEC_W + 1;

   typedef enum logic [1:0] {ST_IDLE, ST_COLLECT, ST_DONE} state_t;

   state_t              state_q, state_d;
   logic [NUM_NETS-1:0] cov0_q, cov0_d, cov1_q, cov1_d;
   logic [NUM_NETS-1:0] newly0, newly1;
   logic [NF-1:0]       newAll, covAll;
   logic [DET_W-1:0]    det_q, det_d, newCount;
   logic [VCNT_W-1:0]   vec_q, vec_d;
   logic                full_q, full_d;
   logic [VEC_W-1:0]    firstVec_q [NF];
   logic                rdValid_q, rdDet_q;
   logic [VEC_W-1:0]    rdFirst_q;
   logic                inReady, accept;

   assign inReady = (state_q == ST_COLLECT) && !START;
   assign accept  = IN_VALID && inReady;
   assign newly0  = IN_DETECT_SA0 & ~cov0_q;
   assign newly1  = IN_DETECT_SA1 & ~cov1_q;
   assign newAll  = {newly1, newly0};
   assign covAll  = {cov1_q, cov0_q};

   always_comb begin
      state_d  = state_q;
      cov0_d   = cov0_q;
      cov1_d   = cov1_q;
      det_d    = det_q;
      vec_d    = vec_q;
      full_d   = full_q;
      newCount = '0;
      for (int j = 0; j < NUM_NETS; j++) begin
         newCount = newCount + DET_W'(newly0[j]) + DET_W'(newly1[j]);
      end
      // START wins over a same-cycle beat; that beat is simply never accepted.
      if (START) begin
         cov0_d  = '0;
         cov1_d  = '0;
         det_d   = '0;
         vec_d   = '0;
         full_d  = 1'b0;
         state_d = ST_COLLECT;
      end else if (accept) begin
         cov0_d = cov0_q | IN_DETECT_SA0;
         cov1_d = cov1_q | IN_DETECT_SA1;
         det_d  = det_q + newCount;
         if (vec_q != {VCNT_W{1'b1}}) begin
            vec_d = vec_q + VCNT_W'(1);
         end
         full_d = (det_d == DET_W'(NF));
`ifdef FAULT_COLLECT_EARLY_STOP_EN
         if (IN_LAST || full_d) begin
            state_d = ST_DONE;
         end
`else
         if (IN_LAST) begin
            state_d = ST_DONE;
         end
`endif
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= ST_IDLE;
         cov0_q  <= '0;
         cov1_q  <= '0;
         det_q   <= '0;
         vec_q   <= '0;
         full_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cov0_q  <= cov0_d;
         cov1_q  <= cov1_d;
         det_q   <= det_d;
         vec_q   <= vec_d;
         full_q  <= full_d;
      end
   end

   // Only faults newly detected by this beat capture the vector; earlier entries are preserved.
   always_ff @(posedge CLK) begin
      for (int f = 0; f < NF; f++) begin
         if (RST || START) begin
            firstVec_q[f] <= '0;
         end else if (accept && newAll[f]) begin
            firstVec_q[f] <= IN_VECTOR;
         end
      end
   end

   // Reads see the registered state, so a read alongside an update returns pre-update data.
   always_ff @(posedge CLK) begin
      if (RST) begin
         rdValid_q <= 1'b0;
         rdDet_q   <= 1'b0;
         rdFirst_q <= '0;
      end else begin
         rdValid_q <= RD_EN;
         if (RD_EN) begin
            rdDet_q   <= 1'b0;
            rdFirst_q <= '0;
            for (int f = 0; f < NF; f++) begin
               if (RD_ADDR == ADDR_W'(f)) begin
                  rdDet_q   <= covAll[f];
                  rdFirst_q <= firstVec_q[f];
               end
            end
         end
      end
   end

   assign IN_READY      = inReady;
   assign COVERED_SA0   = cov0_q;
   assign COVERED_SA1   = cov1_q;
   assign DET_COUNT     = det_q;
   assign VEC_COUNT     = vec_q;
   assign DONE          = (state_q == ST_DONE);
   assign FULL_COVERAGE = full_q;
   assign RD_VALID      = rdValid_q;
   assign RD_DETECTED   = rdDet_q;
   assign RD_FIRST_VEC  = rdFirst_q;

endmodule

// File: tb/tb_fault_coverage_collector.sv
// Bench for fault_coverage_collector: vector table, corner sequences and random beats vs a fault-list model.
module tb_fault_coverage_collector;
   localparam int N  = 8;
   localparam int NF = 2 * N;
   localparam int VW = 4;

   logic           CLK;
   logic           rst, start, inValid, inLast, rdEn;
   logic           inReady, done, fullCov, rdValid, rdDetected;
   logic [VW-1:0]  inVector, rdFirstVec;
   logic [N-1:0]   sa0, sa1, covSa0, covSa1;
   logic [4:0]     detCount;
   logic [VW:0]    vecCount;
   logic [4:0]     rdAddr;

   int checks = 0;
   int errors = 0;

   // Reference model: a flat fault list indexed like the dictionary
   int mState;
   bit mCov [NF];
   int mFirst [NF];
   int mDet, mVec;
   bit mFull, mRdValid, mRdDet;
   int mRdFirst;

   typedef struct {
      logic       start, valid;
      logic [3:0] vector;
      logic [7:0] sa0, sa1;
      logic       last, rdEn;
      logic [4:0] rdAddr;
      logic [7:0] expCov1;
      int         expDet, expVec;
      logic       expReady, expDone, expRdValid, expRdDet;
      logic [3:0] expRdFirst;
   } vecRec_t;

   vecRec_t tbl [9];

   fault_coverage_collector #(.NUM_NETS(N), .VEC_W(VW)) dut (
      .CLK(CLK), .RST(rst), .START(start), .IN_VALID(inValid), .IN_READY(inReady),
      .IN_VECTOR(inVector), .IN_DETECT_SA0(sa0), .IN_DETECT_SA1(sa1), .IN_LAST(inLast),
      .COVERED_SA0(covSa0), .COVERED_SA1(covSa1), .DET_COUNT(detCount), .VEC_COUNT(vecCount),
      .DONE(done), .FULL_COVERAGE(fullCov), .RD_EN(rdEn), .RD_ADDR(rdAddr),
      .RD_VALID(rdValid), .RD_DETECTED(rdDetected), .RD_FIRST_VEC(rdFirstVec)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   function automatic vecRec_t mkRec(logic st, logic v, logic [3:0] vec, logic [7:0] s1, logic l,
                                     logic re, logic [4:0] ra, logic [7:0] eC1, int eD, int eV,
                                     logic eR, logic eDn, logic eRdV, logic eRdD, logic [3:0] eRdF);
      vecRec_t r;
      r.start = st; r.valid = v; r.vector = vec; r.sa0 = 8'h00; r.sa1 = s1; r.last = l;
      r.rdEn = re; r.rdAddr = ra; r.expCov1 = eC1; r.expDet = eD; r.expVec = eV;
      r.expReady = eR; r.expDone = eDn; r.expRdValid = eRdV; r.expRdDet = eRdD; r.expRdFirst = eRdF;
      return r;
   endfunction

   task automatic checkVal(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic modelStep(input bit r, input bit st, input bit v, input int vec, input int s0,
                            input int s1, input bit l, input bit re, input int ra);
      bit d;
      if (r) begin
         mState = 0; mDet = 0; mVec = 0; mFull = 0; mRdValid = 0; mRdDet = 0; mRdFirst = 0;
         for (int f = 0; f < NF; f++) begin mCov[f] = 0; mFirst[f] = 0; end
         return;
      end
      mRdValid = re;
      if (re) begin
         if (ra < NF) begin mRdDet = mCov[ra]; mRdFirst = mFirst[ra]; end
         else begin mRdDet = 0; mRdFirst = 0; end
      end
      if (st) begin
         mState = 1; mDet = 0; mVec = 0; mFull = 0;
         for (int f = 0; f < NF; f++) begin mCov[f] = 0; mFirst[f] = 0; end
      end else if (mState == 1 && v) begin
         for (int f = 0; f < NF; f++) begin
            d = (f < N) ? s0[f] : s1[f - N];
            if (d && !mCov[f]) begin mCov[f] = 1; mFirst[f] = vec; mDet++; end
         end
         if (mVec < 31) mVec++;
         mFull = (mDet == NF);
`ifdef FAULT_COLLECT_EARLY_STOP_EN
         if (l || mFull) mState = 2;
`else
         if (l) mState = 2;
`endif
      end
   endtask

   task automatic applyStimulus(input bit r, input bit st, input bit v, input logic [3:0] vec,
                                input logic [7:0] s0, input logic [7:0] s1, input bit l,
                                input bit re, input logic [4:0] ra);
      rst = r; start = st; inValid = v; inVector = vec; sa0 = s0; sa1 = s1; inLast = l;
      rdEn = re; rdAddr = ra;
      @(posedge CLK);
      #1;
      modelStep(r, st, v, int'(vec), int'(s0), int'(s1), l, re, int'(ra));
      rst = 0; start = 0; inValid = 0; inLast = 0; rdEn = 0;
      #1;
   endtask

   task automatic checkOutput(input string tag);
      logic [7:0] e0, e1;
      for (int j = 0; j < N; j++) begin e0[j] = mCov[j]; e1[j] = mCov[N + j]; end
      checkVal({tag, ".covSa0"}, int'(covSa0), int'(e0));
      checkVal({tag, ".covSa1"}, int'(covSa1), int'(e1));
      checkVal({tag, ".detCount"}, int'(detCount), mDet);
      checkVal({tag, ".vecCount"}, int'(vecCount), mVec);
      checkVal({tag, ".done"}, int'(done), int'(mState == 2));
      checkVal({tag, ".fullCov"}, int'(fullCov), int'(mFull));
      checkVal({tag, ".inReady"}, int'(inReady), int'(mState == 1 && !start));
      checkVal({tag, ".rdValid"}, int'(rdValid), int'(mRdValid));
      checkVal({tag, ".rdDetected"}, int'(rdDetected), int'(mRdDet));
      checkVal({tag, ".rdFirstVec"}, int'(rdFirstVec), mRdFirst);
   endtask

   initial begin
      rst = 1; start = 0; inValid = 0; inVector = 0; sa0 = 0; sa1 = 0; inLast = 0;
      rdEn = 0; rdAddr = 0;

      tbl[0] = mkRec(1, 0, 4'h0, 8'h00, 0, 0, 5'd0,  8'h00, 0, 0, 1, 0, 0, 0, 4'h0);
      tbl[1] = mkRec(0, 1, 4'h0, 8'h80, 0, 0, 5'd0,  8'h80, 1, 1, 1, 0, 0, 0, 4'h0);
      tbl[2] = mkRec(0, 1, 4'h5, 8'hC0, 0, 0, 5'd0,  8'hC0, 2, 2, 1, 0, 0, 0, 4'h0);
      tbl[3] = mkRec(0, 0, 4'h0, 8'h00, 0, 1, 5'd15, 8'hC0, 2, 2, 1, 0, 1, 1, 4'h0);
      tbl[4] = mkRec(0, 0, 4'h0, 8'h00, 0, 1, 5'd14, 8'hC0, 2, 2, 1, 0, 1, 1, 4'h5);
      tbl[5] = mkRec(0, 0, 4'h0, 8'h00, 0, 1, 5'd16, 8'hC0, 2, 2, 1, 0, 1, 0, 4'h0);
      tbl[6] = mkRec(0, 1, 4'h3, 8'hC0, 1, 0, 5'd0,  8'hC0, 2, 3, 0, 1, 0, 0, 4'h0);
      tbl[7] = mkRec(0, 1, 4'h1, 8'h01, 0, 0, 5'd0,  8'hC0, 2, 3, 0, 1, 0, 0, 4'h0);
      tbl[8] = mkRec(1, 1, 4'h2, 8'hFF, 0, 0, 5'd0,  8'h00, 0, 0, 1, 0, 0, 0, 4'h0);

      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("reset");
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
      checkVal("idle.inReady", int'(inReady), 0);
      checkVal("idle.done", int'(done), 0);

      for (int i = 0; i < 9; i++) begin
         applyStimulus(0, tbl[i].start, tbl[i].valid, tbl[i].vector, tbl[i].sa0, tbl[i].sa1,
                       tbl[i].last, tbl[i].rdEn, tbl[i].rdAddr);
         checkVal($sformatf("tbl%0d.covSa1", i), int'(covSa1), int'(tbl[i].expCov1));
         checkVal($sformatf("tbl%0d.detCount", i), int'(detCount), tbl[i].expDet);
         checkVal($sformatf("tbl%0d.vecCount", i), int'(vecCount), tbl[i].expVec);
         checkVal($sformatf("tbl%0d.inReady", i), int'(inReady), int'(tbl[i].expReady));
         checkVal($sformatf("tbl%0d.done", i), int'(done), int'(tbl[i].expDone));
         checkVal($sformatf("tbl%0d.rdValid", i), int'(rdValid), int'(tbl[i].expRdValid));
         if (tbl[i].expRdValid) begin
            checkVal($sformatf("tbl%0d.rdDetected", i), int'(rdDetected), int'(tbl[i].expRdDet));
            checkVal($sformatf("tbl%0d.rdFirstVec", i), int'(rdFirstVec), int'(tbl[i].expRdFirst));
         end
         checkOutput($sformatf("tbl%0d", i));
      end

      // 16 zero-detect beats with gaps, IN_LAST on the 16th, then an ignored 17th
      applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0);
      for (int v = 0; v < 16; v++) begin
         if (v % 3 == 1) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
         applyStimulus(0, 0, 1, 4'(v), 0, 0, (v == 15), 0, 0);
         checkOutput($sformatf("seq16.v%0d", v));
      end
      checkVal("seq16.vecCount", int'(vecCount), 16);
      checkVal("seq16.done", int'(done), 1);
      checkVal("seq16.inReady", int'(inReady), 0);
      applyStimulus(0, 0, 1, 4'h7, 8'hFF, 8'hFF, 1, 0, 0);
      checkVal("seq16.extraVec", int'(vecCount), 16);
      checkVal("seq16.extraDet", int'(detCount), 0);

      // VEC_COUNT saturation over a long session
      applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0);
      for (int v = 0; v < 35; v++) applyStimulus(0, 0, 1, 4'(v), 0, 0, (v == 34), 0, 0);
      checkVal("sat.vecCount", int'(vecCount), 31);
      checkOutput("sat");

      // Reset mid-session after 5 beats
      applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0);
      for (int v = 0; v < 5; v++) applyStimulus(0, 0, 1, 4'(v + 1), 8'(1 << v), 8'(3 << v), 0, 0, 0);
      checkOutput("preRst");
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("midRst");
      checkVal("midRst.detCount", int'(detCount), 0);
      checkVal("midRst.inReady", int'(inReady), 0);
      for (int a = 0; a <= 16; a++) begin
         applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 5'(a));
         checkVal($sformatf("rstRd%0d.rdDetected", a), int'(rdDetected), 0);
         checkVal($sformatf("rstRd%0d.rdFirstVec", a), int'(rdFirstVec), 0);
      end

      // Single beat covering every fault
      applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 1, 4'h9, 8'hFF, 8'hFF, 0, 0, 0);
      checkVal("full.detCount", int'(detCount), 16);
      checkVal("full.fullCov", int'(fullCov), 1);
`ifdef FAULT_COLLECT_EARLY_STOP_EN
      checkVal("full.done", int'(done), 1);
      checkVal("full.inReady", int'(inReady), 0);
`else
      checkVal("full.done", int'(done), 0);
      checkVal("full.inReady", int'(inReady), 1);
      applyStimulus(0, 0, 1, 4'hA, 8'hFF, 8'h00, 0, 1, 5'd3);
      checkVal("full.moreVec", int'(vecCount), 2);
      checkVal("full.rdFirstVec", int'(rdFirstVec), 9);
`endif
      checkOutput("full");

      // Randomized traffic against the model
      for (int c = 0; c < 800; c++) begin
         bit r, st, v, l, re;
         r  = ($urandom_range(0, 299) == 0);
         st = ($urandom_range(0, 39) == 0) || (mState != 1 && $urandom_range(0, 7) == 0);
         v  = $urandom_range(0, 3) != 0;
         l  = ($urandom_range(0, 24) == 0);
         re = $urandom_range(0, 1) == 1;
         applyStimulus(r, st, v, 4'($urandom), 8'($urandom & $urandom & $urandom),
                       8'($urandom & $urandom & $urandom), l, re, 5'($urandom_range(0, 17)));
         checkOutput($sformatf("rnd%0d", c));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fault_coverage_collector.md
Name: fault_coverage_collector

Overview:
- Hardware sink for the per-vector detect words produced by the parallel stuck-at fault simulator; the receiving end of the stream that the exhaustive vector driver produces.
- Accepts one {vector, SA0 detect word, SA1 detect word} beat per handshake and accumulates the covered-fault masks.
- Records, for each fault, the first vector that detected it, and keeps vector and detected-fault counts.
- Results are exposed as live masks and through a random-access fault-dictionary read port.

Parameters:
- NUM_NETS, 8, number of nets under fault; fault list size is 2*NUM_NETS.
- VEC_W, 4, test vector width (ABCD).

Ports:
- CLK  in  1  clock, all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- START  in  1  clear all results and open a collection session.
- IN_VALID  in  1  beat valid.
- IN_READY  out  1  collector can accept a beat.
- IN_VECTOR  in  VEC_W  vector applied for this beat.
- IN_DETECT_SA0  in  NUM_NETS  bit j=1: net j stuck-at-0 detected.
- IN_DETECT_SA1  in  NUM_NETS  bit j=1: net j stuck-at-1 detected.
- IN_LAST  in  1  final beat of session.
- COVERED_SA0  out  NUM_NETS  accumulated SA0 detection mask.
- COVERED_SA1  out  NUM_NETS  accumulated SA1 detection mask.
- DET_COUNT  out  clog2(2*NUM_NETS+1)  number of distinct faults detected.
- VEC_COUNT  out  VEC_W+1  beats accepted this session.
- DONE  out  1  session closed.
- FULL_COVERAGE  out  1  all 2*NUM_NETS faults detected.
- RD_EN  in  1  dictionary read request.
- RD_ADDR  in  clog2(2*NUM_NETS)+1  fault index: 0..N-1 = net SA0, N..2N-1 = net SA1.
- RD_VALID  out  1  read data valid.
- RD_DETECTED  out  1  fault at RD_ADDR detected.
- RD_FIRST_VEC  out  VEC_W  first vector that detected the fault.

Behaviour:
- Reset: state IDLE. All outputs 0, including IN_READY, masks, counts, DONE, FULL_COVERAGE, RD_*. The first-vector table is cleared to 0.
- Reset mid-session discards everything; the block returns to IDLE.
- FSM states:
  - IDLE -> COLLECT on START.
  - COLLECT -> DONE after accepting a beat with IN_LAST=1.
  - DONE -> COLLECT on START.
- START in any state, one cycle: clears masks, counts, table, DONE and FULL_COVERAGE, then enters COLLECT. START has priority over a same-cycle beat; that beat is not accepted.
- IN_READY = 1 only in COLLECT and not START. A beat is accepted when IN_VALID & IN_READY.
- On an accepted beat, with newly = detect & ~covered (per polarity):
  - covered |= detect.
  - first_vec[f] = IN_VECTOR for each newly set fault f; faults that were already detected are never overwritten.
  - DET_COUNT += popcount(newly SA0) + popcount(newly SA1).
  - VEC_COUNT += 1, saturating at 2^(VEC_W+1)-1.
- All result outputs are registered and reflect a beat on the cycle after acceptance.
- A beat with both detect words zero still increments VEC_COUNT.
- FULL_COVERAGE = (DET_COUNT == 2*NUM_NETS), registered alongside the counts.
- In DONE, IN_VALID is ignored and results hold.
- Read port, valid in any state:
  - RD_EN sampled -> RD_VALID=1 next cycle for one cycle, with RD_DETECTED/RD_FIRST_VEC for RD_ADDR.
  - RD_ADDR >= 2*NUM_NETS returns 0/0.
  - A read coincident with an update returns the pre-update value.
  - RD_VALID=0 when RD_EN=0; data outputs then hold their last value.

Optional Feature:
- Macro: FAULT_COLLECT_EARLY_STOP_EN.
- Defined: when the update makes DET_COUNT reach 2*NUM_NETS, the FSM enters DONE on that same update edge, so IN_READY is low from the next cycle. Remaining beats are stalled, and IN_LAST is not required.
- Undefined: collection continues until an IN_LAST beat. Further beats after full coverage still increment VEC_COUNT only.

Test Plan:
- Reset then idle: all outputs 0, IN_READY=0. After START, IN_READY=1 the next cycle and VEC_COUNT=0.
- Beats v=0000 SA1=8'b1000_0000 then v=0101 SA1=8'b1100_0000 -> COVERED_SA1=8'b1100_0000, DET_COUNT=2. A read of fault 8+7 gives RD_FIRST_VEC=0000; a read of fault 8+6 gives 0101.
- 16 beats v=0..15, IN_LAST on v=15, IN_VALID toggled with gaps -> VEC_COUNT=16, DONE=1, IN_READY=0. A 17th IN_VALID is ignored.
- START asserted together with a valid beat in DONE -> beat not accepted; masks/counts cleared; VEC_COUNT=0 next cycle.
- RST pulsed after 5 beats -> all results 0, state IDLE. A read of any address gives RD_DETECTED=0. RD_ADDR=16 always returns 0/0.
- Single beat with SA0=SA1=8'hFF:
  - Without macro: FULL_COVERAGE=1, DET_COUNT=16, IN_READY stays 1.
  - With FAULT_COLLECT_EARLY_STOP_EN: DONE=1 and IN_READY=0 the next cycle.
